lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store sequencer between execute stage, data memory port and writeback data-memory path.
- Accepts one memory op at a time and drives a req/ready handshake to data memory.
- Generates byte enables and lane-shifted store data; aligns and sign/zero-extends load data by funct3 and address low bits.
- Stalls the pipeline until the access completes; presents final load data to writeback for the DTAMEM select.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT_CYCLES, 255, cycles in BUSY before abort (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ex_valid  input  1  execute stage presents an instruction this cycle.
- ex_is_load  input  1  instruction is a load.
- ex_is_store  input  1  instruction is a store.
- ex_funct3  input  3  load/store width code.
- ex_addr  input  ADDR_W  effective byte address.
- ex_store_data  input  32  rs2 value, unshifted.
- mem_req  output  1  memory request valid.
- mem_we  output  1  1 = write.
- mem_addr  output  ADDR_W  word-aligned address (bits [1:0] = 0).
- mem_wdata  output  32  lane-shifted store data.
- mem_be  output  4  byte enables.
- mem_ready  input  1  memory completes the request this cycle.
- mem_rdata  input  32  read word, valid when mem_ready.
- stall  output  1  freeze IF/ID/EX.
- wb_valid  output  1  one-cycle pulse: access complete.
- wb_load_data  output  32  aligned, extended load result.
- misaligned  output  1  one-cycle exception pulse.
- bus_error  output  1  one-cycle timeout pulse (optional feature only; else tied 0).

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_req, mem_we, mem_be, wb_valid, misaligned, bus_error = 0; mem_addr, mem_wdata, wb_load_data = 0. Reset mid-access drops mem_req immediately and discards the op; no wb_valid.
- Op accepted in IDLE when ex_valid & (ex_is_load | ex_is_store). If both flags are set, treat as load.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0. Response: misaligned pulses the next cycle, no memory access, stall never asserted, stay IDLE.
- Illegal funct3 (011, 110, 111; stores also 1xx) is treated as word.
- States:
  - IDLE -> BUSY on an aligned op. funct3, addr[1:0], we and lane data are registered.
  - BUSY: mem_req=1, all request outputs held stable until mem_ready is sampled 1. On mem_ready: capture the aligned load result into wb_load_data, go RESP.
  - RESP: wb_valid=1 for one cycle, mem_req=0, -> IDLE. A new op may be accepted in the following IDLE cycle.
- stall = (IDLE & accepting an aligned op) | BUSY. Low in RESP, so the pipeline advances with the writeback data valid.
- Latency: with mem_ready high in the first BUSY cycle, wb_valid occurs 2 cycles after acceptance. Each extra wait cycle adds 1.
- Store lanes:
  - SB: be = 0001 << addr[1:0]; byte replicated x4.
  - SH: be = 0011 << addr[1:0]; halfword replicated x2.
  - SW: be = 1111.
- Loads:
  - mem_be = 1111.
  - Byte = rdata >> (8*addr[1:0]); half = rdata >> (8*addr[1:0]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- wb_load_data holds its value until the next completed load. For stores it is unchanged.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - 8-bit-minimum counter clears on BUSY entry and increments each BUSY cycle.
  - Reaching TIMEOUT_CYCLES with no mem_ready: drop mem_req, pulse bus_error for one cycle, return to IDLE, no wb_valid.
  - mem_ready in the same cycle as the timeout wins (normal completion).
- Undefined: no counter; BUSY waits indefinitely; bus_error tied 0.

Decomposition:
- Shared package/defines file holds:
  - funct3 codes LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
  - State encodings IDLE/BUSY/RESP.
  - Writeback mux selects ALUOUT_SEL, PC_P_4_SEL, DTAMEM_SEL.
- One natural combinational sub-module: load_align, taking rdata, addr[1:0] and funct3, producing the extended 32-bit result.

Test Plan:
- LW addr 0x100, rdata 0xDEADBEEF, mem_ready in first BUSY cycle -> mem_addr 0x100, be 1111, stall 2 cycles, wb_load_data 0xDEADBEEF with wb_valid at cycle 2.
- LB addr 0x103, rdata 0x80FF0000 -> 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x102 -> 0x000080FF.
- SH addr 0x206, data 0x1234ABCD -> mem_addr 0x204, be 1100, wdata 0xABCDABCD, mem_we=1.
- LW addr 0x101 -> misaligned pulse, mem_req never asserted, stall stays 0.
- mem_ready delayed 5 cycles, with rst_n pulsed low in wait cycle 3 -> mem_req drops immediately, no wb_valid, outputs at reset values.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready held 0 -> bus_error pulse after 4 BUSY cycles, then IDLE, stall low.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared definitions for the load/store sequencer.
//   - funct3 width codes for loads and stores
//   - sequencer state encoding
//   - writeback mux selects (DTAMEM_SEL picks wb_load_data)
//   - access-size decode helpers shared by the top and the bench-facing logic
package lsu_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  localparam logic [1:0] ALUOUT_SEL = 2'd0;
  localparam logic [1:0] PC_P_4_SEL = 2'd1;
  localparam logic [1:0] DTAMEM_SEL = 2'd2;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_e;

  // Op fields held for the whole access.
  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } lsu_op_t;

  // Illegal codes fall through to word; stores only know SB/SH.
  function automatic acc_size_e access_size(input logic is_load, input logic [2:0] f3);
    acc_size_e sz;
    sz = SZ_W;
    if (is_load) begin
      case (f3)
        F3_LB, F3_LBU: sz = SZ_B;
        F3_LH, F3_LHU: sz = SZ_H;
        default:       sz = SZ_W;
      endcase
    end else begin
      case (f3)
        F3_SB:   sz = SZ_B;
        F3_SH:   sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] lo);
    return ((sz == SZ_H) && lo[0]) || ((sz == SZ_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_ctrl_load_align.sv
// lsu_ctrl_load_align: combinational load alignment and extension.
//   rdata   - raw memory word
//   addr_lo - byte offset of the access
//   funct3  - load width code (illegal codes pass the word through)
//   result  - aligned, sign/zero-extended value
module lsu_ctrl_load_align
  import lsu_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [3:0][7:0] lanes;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;

  always_comb begin
    lanes  = rdata;
    byte_v = lanes[addr_lo];
    // Halfwords are 2-byte aligned, so only addr_lo[1] picks the pair.
    half_v = {lanes[{addr_lo[1], 1'b1}], lanes[{addr_lo[1], 1'b0}]};
    case (funct3)
      F3_LB:   result = {{24{byte_v[7]}}, byte_v};
      F3_LH:   result = {{16{half_v[15]}}, half_v};
      F3_LBU:  result = {24'd0, byte_v};
      F3_LHU:  result = {16'd0, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between EX, the data memory port and WB.
// One op in flight. IDLE accepts, BUSY holds the request until mem_ready,
// RESP pulses wb_valid. Misaligned ops pulse `misaligned` and never touch
// memory.
// Ports:
//   clk, rst_n                   - clock, async active-low reset
//   ex_*                         - op from execute (load wins if both flags)
//   mem_req/we/addr/wdata/be     - memory request, held stable in BUSY
//   mem_ready, mem_rdata         - memory completion and read word
//   stall                        - freezes IF/ID/EX during the access
//   wb_valid, wb_load_data       - completion pulse and held load result
//   misaligned, bus_error        - one-cycle exception pulses
// Optional: define LSU_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES cycles
// without mem_ready (bus_error pulse). Without it bus_error is tied 0.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic              wb_valid,
  output logic [31:0]       wb_load_data,
  output logic              misaligned,
  output logic              bus_error
);

  lsu_state_e state_q, state_d;
  lsu_op_t    op_q;
  acc_size_e  sz;
  logic       accept, mis, go, timeout;
  logic [3:0] be_d;
  logic [31:0] wdata_d, ld_result;

  always_comb begin
    sz      = access_size(ex_is_load, ex_funct3);
    mis     = is_misaligned(sz, ex_addr[1:0]);
    accept  = (state_q == ST_IDLE) && ex_valid && (ex_is_load || ex_is_store);
    go      = accept && !mis;
    be_d    = 4'b1111;
    wdata_d = '0;
    if (!ex_is_load) begin
      case (sz)
        SZ_B: begin
          be_d    = 4'b0001 << ex_addr[1:0];
          wdata_d = {4{ex_store_data[7:0]}};
        end
        SZ_H: begin
          be_d    = 4'b0011 << ex_addr[1:0];
          wdata_d = {2{ex_store_data[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = ex_store_data;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // mem_req/stall/wb_valid decode from state so reset drops them at once.
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    stall    = 1'b0;
    wb_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_BUSY;
          stall   = 1'b1;
        end
      end
      ST_BUSY: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ready)    state_d = ST_RESP;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_RESP: begin
        wb_valid = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  lsu_ctrl_load_align u_load_align (
    .rdata   (mem_rdata),
    .addr_lo (op_q.addr_lo),
    .funct3  (op_q.funct3),
    .result  (ld_result)
  );

  assign mem_we = op_q.we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      wb_load_data <= '0;
      misaligned   <= 1'b0;
    end else begin
      misaligned <= accept && mis;
      if (go) begin
        op_q      <= '{we: !ex_is_load, funct3: ex_funct3, addr_lo: ex_addr[1:0]};
        mem_addr  <= {ex_addr[ADDR_W-1:2], 2'b00};
        mem_wdata <= wdata_d;
        mem_be    <= be_d;
      end
      if ((state_q == ST_BUSY) && mem_ready && !op_q.we)
        wb_load_data <= ld_result;
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES + 1 > 256) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] to_cnt;

  // to_cnt == number of BUSY cycles already spent; the last allowed cycle
  // is the one where it reads TIMEOUT_CYCLES-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   to_cnt <= '0;
    else if (go)                  to_cnt <= '0;
    else if (state_q == ST_BUSY)  to_cnt <= to_cnt + CNT_W'(1);
  end

  assign timeout = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus_error <= 1'b0;
    else        bus_error <= (state_q == ST_BUSY) && !mem_ready && timeout;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout   = 1'b0;
  assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed + randomized bench for lsu_ctrl with a byte-level
// arithmetic reference model. Define LSU_TIMEOUT_EN to also run the abort case.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_store_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall, wb_valid, misaligned, bus_error;
  logic [31:0] wb_load_data;

  int tests = 0;
  int fails = 0;
  logic [31:0] wb_exp = 32'h0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall(stall), .wb_valid(wb_valid), .wb_load_data(wb_load_data),
    .misaligned(misaligned), .bus_error(bus_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Access width in bytes.
  function automatic int nbytes(input bit ld, input logic [2:0] f3);
    if (ld) begin
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
    end
    if (f3 == 3'd0) return 1;
    if (f3 == 3'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_wdata(input int n, input logic [31:0] d);
    if (n == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int n;
    logic [31:0] v;
    n = nbytes(1'b1, f3);
    if (n == 4) return rd;
    v = rd >> (8 * (a % 4));
    if (n == 1) begin
      v = v & 32'hFF;
      if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
    end else begin
      v = v & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One op starting in an IDLE cycle; ends at posedge+1 of the next IDLE cycle.
  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input int waits, input logic [31:0] rd);
    int n;
    bit mis;
    logic [31:0] be_exp;
    n   = nbytes(ld, f3);
    mis = (a % n) != 0;
    be_exp = ld ? 32'hF : ((n == 4) ? 32'hF : ((32'd1 << n) - 1) << (a % 4));
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
    ex_funct3 = f3; ex_addr = a; ex_store_data = sd;
    #1 chk("stall_accept", {31'd0, stall}, {31'd0, !mis});
    step();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    if (mis) begin
      chk("misaligned_pulse", {31'd0, misaligned}, 32'd1);
      chk("misaligned_req", {31'd0, mem_req}, 32'd0);
      chk("misaligned_stall", {31'd0, stall}, 32'd0);
      step();
      chk("misaligned_clear", {31'd0, misaligned}, 32'd0);
      chk("misaligned_req2", {31'd0, mem_req}, 32'd0);
      return;
    end
    for (int w = 0; w <= waits; w++) begin
      chk("busy_req", {31'd0, mem_req}, 32'd1);
      chk("busy_stall", {31'd0, stall}, 32'd1);
      chk("busy_we", {31'd0, mem_we}, {31'd0, !ld});
      chk("busy_addr", mem_addr, a & 32'hFFFF_FFFC);
      chk("busy_be", {28'd0, mem_be}, be_exp);
      if (!ld) chk("busy_wdata", mem_wdata, exp_wdata(n, sd));
      chk("busy_wb_valid", {31'd0, wb_valid}, 32'd0);
      mem_ready = (w == waits);
      mem_rdata = (w == waits) ? rd : $urandom;
      step();
    end
    mem_ready = 1'b0;
    if (ld) wb_exp = exp_load(f3, a, rd);
    chk("resp_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("resp_stall", {31'd0, stall}, 32'd0);
    chk("resp_req", {31'd0, mem_req}, 32'd0);
    chk("resp_wb_data", wb_load_data, wb_exp);
    chk("resp_bus_error", {31'd0, bus_error}, 32'd0);
    step();
    chk("idle_wb_valid", {31'd0, wb_valid}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   {31'd0, mem_req}, 32'd0);
    chk({tag, "_we"},    {31'd0, mem_we}, 32'd0);
    chk({tag, "_be"},    {28'd0, mem_be}, 32'd0);
    chk({tag, "_addr"},  mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_wbd"},   wb_load_data, 32'd0);
    chk({tag, "_wbv"},   {31'd0, wb_valid}, 32'd0);
    chk({tag, "_mis"},   {31'd0, misaligned}, 32'd0);
    chk({tag, "_berr"},  {31'd0, bus_error}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_funct3 = 3'd0; ex_addr = 32'd0; ex_store_data = 32'd0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
    #2 chk_reset_vals("reset");
    step(); step();
    rst_n = 1'b1;
    step();

    // Directed cases.
    do_op(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
    do_op(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_0000);
    do_op(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_0000);
    do_op(1, 0, 3'b101, 32'h102, 32'h0, 2, 32'h80FF_0000);
    do_op(1, 0, 3'b001, 32'h102, 32'h0, 0, 32'h80FF_0000);
    do_op(0, 1, 3'b001, 32'h206, 32'h1234_ABCD, 0, 32'h0);
    do_op(0, 1, 3'b000, 32'h209, 32'h0000_0077, 1, 32'h0);
    do_op(0, 1, 3'b110, 32'h20C, 32'hCAFE_F00D, 0, 32'h0);
    do_op(1, 1, 3'b010, 32'h300, 32'h5555_5555, 0, 32'h1357_9BDF);
    do_op(1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h0);
    do_op(0, 1, 3'b001, 32'h203, 32'h0, 0, 32'h0);

    // ex_valid without a memory op is ignored.
    ex_valid = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h40;
    #1 chk("noop_stall", {31'd0, stall}, 32'd0);
    step();
    ex_valid = 1'b0;
    chk("noop_req", {31'd0, mem_req}, 32'd0);
    chk("noop_mis", {31'd0, misaligned}, 32'd0);

    // Reset in the third wait cycle of a slow load.
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h400;
    step();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    for (int w = 1; w <= 3; w++) begin
      chk("rst_wait_req", {31'd0, mem_req}, 32'd1);
      if (w < 3) step();
    end
    rst_n = 1'b0;
    #1 chk_reset_vals("midreset");
    #2 rst_n = 1'b1;
    wb_exp = 32'h0;
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("postrst_wbv", {31'd0, wb_valid}, 32'd0);
      chk("postrst_req", {31'd0, mem_req}, 32'd0);
      chk("postrst_wbd", wb_load_data, 32'd0);
    end
    mem_ready = 1'b0;
    do_op(1, 0, 3'b010, 32'h500, 32'h0, 0, 32'h0BAD_F00D);

`ifdef LSU_TIMEOUT_EN
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h600;
    step();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    for (int w = 0; w < 4; w++) begin
      chk("to_req", {31'd0, mem_req}, 32'd1);
      chk("to_berr_low", {31'd0, bus_error}, 32'd0);
      step();
    end
    chk("to_berr", {31'd0, bus_error}, 32'd1);
    chk("to_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_stall", {31'd0, stall}, 32'd0);
    chk("to_wbv", {31'd0, wb_valid}, 32'd0);
    step();
    chk("to_berr_clear", {31'd0, bus_error}, 32'd0);
    chk("to_wbv2", {31'd0, wb_valid}, 32'd0);
`endif

    // Randomized ops against the model.
    for (int i = 0; i < 60; i++) begin
      bit ld, st;
      logic [31:0] a;
      ld = 1'($urandom_range(0, 1));
      st = ld ? 1'($urandom_range(0, 1)) : 1'b1;
      a  = $urandom;
      do_op(ld, st, 3'($urandom_range(0, 7)), a, $urandom, $urandom_range(0, 3), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
